// File: rtl/reversi_control.sv
// Sequencing FSM for the Reversi datapath: one-hot stage enables, go handshake, key edges, go watchdog.
// Optional PASS_TURN_EN adds the CUR stage so a player whose opponent cannot move keeps playing.
module reversi_control #(
  parameter int TIMEOUT_W = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_right,
  input  logic       key_left,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_enter,
  input  logic       go,
  input  logic       validMove,
  input  logic       hasTurn,
  output logic       dp_reset,
  output logic       writeEn,
  output logic       drawBoardEn,
  output logic       drawInitialPiecesEn,
  output logic       moveHighlightEn,
  output logic       checkIfValidMoveEn,
  output logic       placeEn,
  output logic       flipEn,
  output logic       scoreManagerEn,
  output logic       determineHasTurnEn,
  output logic       determineOpponent,
  output logic       determineCurrent,
  output logic       TurnManagerEn,
  output logic       removeHighlightEn,
  output logic       moveRightEn,
  output logic       moveLeftEn,
  output logic       moveUpEn,
  output logic       moveDownEn,
  output logic       game_over,
  output logic       fault,
  output logic [4:0] state
);

  typedef enum logic [4:0] {
    S_RESET, S_DRAW_BOARD, S_DRAW_INIT, S_HIGHLIGHT, S_WAIT_INPUT,
    S_MOVE_R, S_MOVE_L, S_MOVE_U, S_MOVE_D, S_CHECK, S_PLACE, S_FLIP,
    S_SCORE, S_OPP, S_SWAP, S_CUR, S_END, S_GAME_OVER, S_FAULT
  } state_t;

  localparam int O_DPRST = 18, O_WR = 17, O_DRAWB = 16, O_DRAWI = 15, O_HL = 14,
                 O_CHK = 13, O_PLACE = 12, O_FLIP = 11, O_SCORE = 10, O_DHT = 9,
                 O_DOPP = 8, O_TURN = 7, O_RMHL = 6, O_MR = 5, O_ML = 4, O_MU = 3,
                 O_MD = 2, O_GO = 1, O_FAULT = 0;

  localparam logic [TIMEOUT_W-1:0] LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t               stateQ, stateN;
  logic [18:0]          outQ;
  logic [4:0]           keys, keyQ, edgeQ;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 tmo;

  assign keys = {key_enter, key_right, key_left, key_up, key_down};

  function automatic logic isWait(state_t s);
    return s inside {S_RESET, S_DRAW_BOARD, S_DRAW_INIT, S_HIGHLIGHT, S_CHECK, S_PLACE,
                     S_FLIP, S_SCORE, S_OPP, S_SWAP, S_CUR, S_END};
  endfunction

  function automatic logic [18:0] decode(state_t s);
    logic [18:0] o;
    o = '0;
    case (s)
      S_RESET:      o[O_DPRST] = 1'b1;
      S_DRAW_BOARD: begin o[O_DRAWB] = 1'b1; o[O_WR] = 1'b1; end
      S_DRAW_INIT:  begin o[O_DRAWI] = 1'b1; o[O_WR] = 1'b1; end
      S_HIGHLIGHT:  begin o[O_HL] = 1'b1; o[O_WR] = 1'b1; end
      S_MOVE_R:     o[O_MR] = 1'b1;
      S_MOVE_L:     o[O_ML] = 1'b1;
      S_MOVE_U:     o[O_MU] = 1'b1;
      S_MOVE_D:     o[O_MD] = 1'b1;
      S_CHECK:      o[O_CHK] = 1'b1;
      S_PLACE:      begin o[O_PLACE] = 1'b1; o[O_WR] = 1'b1; end
      S_FLIP:       begin o[O_FLIP] = 1'b1; o[O_WR] = 1'b1; end
      S_SCORE:      o[O_SCORE] = 1'b1;
      S_OPP:        begin o[O_DHT] = 1'b1; o[O_DOPP] = 1'b1; end
      S_SWAP:       o[O_TURN] = 1'b1;
`ifdef PASS_TURN_EN
      S_CUR:        o[O_DHT] = 1'b1;
`endif
      S_END:        begin o[O_RMHL] = 1'b1; o[O_WR] = 1'b1; end
      S_GAME_OVER:  o[O_GO] = 1'b1;
      S_FAULT:      o[O_FAULT] = 1'b1;
      default:      o = '0;
    endcase
    return o;
  endfunction

  // e = {enter, right, left, up, down}; enter wins, then right..down
  function automatic state_t nextState(state_t s, logic g, logic vm, logic ht,
                                       logic [4:0] e, logic t);
    state_t n;
    n = s;
    if (t) return S_FAULT;
    case (s)
      S_RESET:      if (g) n = S_DRAW_BOARD;
      S_DRAW_BOARD: if (g) n = S_DRAW_INIT;
      S_DRAW_INIT:  if (g) n = S_HIGHLIGHT;
      S_HIGHLIGHT:  if (g) n = S_WAIT_INPUT;
      S_WAIT_INPUT: begin
        if      (e[4]) n = S_CHECK;
        else if (e[3]) n = S_MOVE_R;
        else if (e[2]) n = S_MOVE_L;
        else if (e[1]) n = S_MOVE_U;
        else if (e[0]) n = S_MOVE_D;
      end
      S_MOVE_R, S_MOVE_L, S_MOVE_U, S_MOVE_D: n = S_HIGHLIGHT;
      S_CHECK:      if (g) n = vm ? S_PLACE : S_WAIT_INPUT;
      S_PLACE:      if (g) n = S_FLIP;
      S_FLIP:       if (g) n = S_SCORE;
      S_SCORE:      if (g) n = S_OPP;
`ifdef PASS_TURN_EN
      S_OPP:        if (g) n = ht ? S_SWAP : S_CUR;
      S_CUR:        if (g) n = ht ? S_HIGHLIGHT : S_END;
`else
      S_OPP:        if (g) n = ht ? S_SWAP : S_END;
`endif
      S_SWAP:       if (g) n = S_HIGHLIGHT;
      S_END:        if (g) n = S_GAME_OVER;
      S_GAME_OVER:  if (e[4]) n = S_RESET;
      S_FAULT:      n = S_FAULT;
      default:      n = S_FAULT;
    endcase
    return n;
  endfunction

  // Timeout fires on the cycle the counter would reach all-ones
  assign tmo = isWait(stateQ) && !go && (cnt == LAST);

  always_comb stateN = nextState(stateQ, go, validMove, hasTurn, edgeQ, tmo);

`ifdef PASS_TURN_EN
  logic dcurQ;
  assign determineCurrent = dcurQ;
`else
  assign determineCurrent = 1'b0;
`endif

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      stateQ <= S_RESET;
      outQ   <= decode(S_RESET);
      keyQ   <= '0;
      edgeQ  <= '0;
      cnt    <= '0;
`ifdef PASS_TURN_EN
      dcurQ  <= 1'b0;
`endif
    end else begin
      keyQ   <= keys;
      edgeQ  <= keys & ~keyQ;
      stateQ <= stateN;
      outQ   <= decode(stateN);
`ifdef PASS_TURN_EN
      dcurQ  <= (stateN == S_CUR);
`endif
      if (stateN != stateQ)            cnt <= '0;
      else if (isWait(stateQ) && !go)  cnt <= cnt + ONE;
    end
  end

  assign state               = stateQ;
  assign dp_reset            = outQ[O_DPRST];
  assign writeEn             = outQ[O_WR];
  assign drawBoardEn         = outQ[O_DRAWB];
  assign drawInitialPiecesEn = outQ[O_DRAWI];
  assign moveHighlightEn     = outQ[O_HL];
  assign checkIfValidMoveEn  = outQ[O_CHK];
  assign placeEn             = outQ[O_PLACE];
  assign flipEn              = outQ[O_FLIP];
  assign scoreManagerEn      = outQ[O_SCORE];
  assign determineHasTurnEn  = outQ[O_DHT];
  assign determineOpponent   = outQ[O_DOPP];
  assign TurnManagerEn       = outQ[O_TURN];
  assign removeHighlightEn   = outQ[O_RMHL];
  assign moveRightEn         = outQ[O_MR];
  assign moveLeftEn          = outQ[O_ML];
  assign moveUpEn            = outQ[O_MU];
  assign moveDownEn          = outQ[O_MD];
  assign game_over           = outQ[O_GO];
  assign fault               = outQ[O_FAULT];

endmodule

// File: tb/tb_reversi_control.sv
// Self-checking bench for reversi_control: stage table + transition rules model, random play.
module tb_reversi_control;
  logic clk = 1'b0, resetn = 1'b1;
  logic key_right = 0, key_left = 0, key_up = 0, key_down = 0, key_enter = 0;
  logic go = 0, validMove = 0, hasTurn = 0;
  logic dp_reset, writeEn, drawBoardEn, drawInitialPiecesEn, moveHighlightEn, checkIfValidMoveEn;
  logic placeEn, flipEn, scoreManagerEn, determineHasTurnEn, determineOpponent, determineCurrent;
  logic TurnManagerEn, removeHighlightEn, moveRightEn, moveLeftEn, moveUpEn, moveDownEn;
  logic game_over, fault;
  logic [4:0] state;

  int errors = 0, checks = 0;
  int mrCnt = 0, plCnt = 0, dcurCnt = 0;

  localparam logic [4:0] ST_RESET = 0, ST_DRAW_BOARD = 1, ST_DRAW_INIT = 2, ST_HIGHLIGHT = 3,
    ST_WAIT = 4, ST_MOVE_R = 5, ST_MOVE_L = 6, ST_MOVE_U = 7, ST_MOVE_D = 8, ST_CHECK = 9,
    ST_PLACE = 10, ST_FLIP = 11, ST_SCORE = 12, ST_OPP = 13, ST_SWAP = 14, ST_CUR = 15,
    ST_END = 16, ST_GAME_OVER = 17, ST_FAULT = 18;

  reversi_control #(.TIMEOUT_W(4)) dut (
    .clk(clk), .resetn(resetn), .key_right(key_right), .key_left(key_left), .key_up(key_up),
    .key_down(key_down), .key_enter(key_enter), .go(go), .validMove(validMove), .hasTurn(hasTurn),
    .dp_reset(dp_reset), .writeEn(writeEn), .drawBoardEn(drawBoardEn),
    .drawInitialPiecesEn(drawInitialPiecesEn), .moveHighlightEn(moveHighlightEn),
    .checkIfValidMoveEn(checkIfValidMoveEn), .placeEn(placeEn), .flipEn(flipEn),
    .scoreManagerEn(scoreManagerEn), .determineHasTurnEn(determineHasTurnEn),
    .determineOpponent(determineOpponent), .determineCurrent(determineCurrent),
    .TurnManagerEn(TurnManagerEn), .removeHighlightEn(removeHighlightEn),
    .moveRightEn(moveRightEn), .moveLeftEn(moveLeftEn), .moveUpEn(moveUpEn),
    .moveDownEn(moveDownEn), .game_over(game_over), .fault(fault), .state(state));

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {dp_reset, writeEn, drawBoardEn, drawInitialPiecesEn, moveHighlightEn,
                checkIfValidMoveEn, placeEn, flipEn, scoreManagerEn, determineHasTurnEn,
                determineOpponent, determineCurrent, TurnManagerEn, removeHighlightEn,
                moveRightEn, moveLeftEn, moveUpEn, moveDownEn, game_over, fault};

  always @(negedge clk) begin
    if (moveRightEn)      mrCnt   <= mrCnt + 1;
    if (placeEn)          plCnt   <= plCnt + 1;
    if (determineCurrent) dcurCnt <= dcurCnt + 1;
  end

  // Expected output set per stage, bit order as obs
  function automatic logic [19:0] expOut(logic [4:0] s);
    logic [19:0] o;
    o = '0;
    case (s)
      ST_RESET:      o[19] = 1;
      ST_DRAW_BOARD: begin o[17] = 1; o[18] = 1; end
      ST_DRAW_INIT:  begin o[16] = 1; o[18] = 1; end
      ST_HIGHLIGHT:  begin o[15] = 1; o[18] = 1; end
      ST_CHECK:      o[14] = 1;
      ST_PLACE:      begin o[13] = 1; o[18] = 1; end
      ST_FLIP:       begin o[12] = 1; o[18] = 1; end
      ST_SCORE:      o[11] = 1;
      ST_OPP:        begin o[10] = 1; o[9] = 1; end
      ST_CUR:        begin o[10] = 1; o[8] = 1; end
      ST_SWAP:       o[7] = 1;
      ST_END:        begin o[6] = 1; o[18] = 1; end
      ST_MOVE_R:     o[5] = 1;
      ST_MOVE_L:     o[4] = 1;
      ST_MOVE_U:     o[3] = 1;
      ST_MOVE_D:     o[2] = 1;
      ST_GAME_OVER:  o[1] = 1;
      ST_FAULT:      o[0] = 1;
      default:       o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [4:0] nextOf(logic [4:0] s, logic vm, logic ht);
    case (s)
      ST_RESET:     return ST_DRAW_BOARD;
      ST_DRAW_BOARD:return ST_DRAW_INIT;
      ST_DRAW_INIT: return ST_HIGHLIGHT;
      ST_HIGHLIGHT: return ST_WAIT;
      ST_CHECK:     return vm ? ST_PLACE : ST_WAIT;
      ST_PLACE:     return ST_FLIP;
      ST_FLIP:      return ST_SCORE;
      ST_SCORE:     return ST_OPP;
`ifdef PASS_TURN_EN
      ST_OPP:       return ht ? ST_SWAP : ST_CUR;
`else
      ST_OPP:       return ht ? ST_SWAP : ST_END;
`endif
      ST_CUR:       return ht ? ST_HIGHLIGHT : ST_END;
      ST_SWAP:      return ST_HIGHLIGHT;
      ST_END:       return ST_GAME_OVER;
      default:      return ST_FAULT;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setKeys(input logic [4:0] m);
    {key_enter, key_right, key_left, key_up, key_down} = m;
  endtask

  // Answer the current stage: go low for lat cycles, then one cycle of go with results
  task automatic serve(input int lat, input logic vm, input logic ht);
    repeat (lat) @(negedge clk);
    go = 1; validMove = vm; hasTurn = ht;
    @(negedge clk);
    go = 0; validMove = 0; hasTurn = 0;
  endtask

  // Follow wait stages from cur until WAIT_INPUT or GAME_OVER; lat<0 means random latency
  task automatic walk(inout logic [4:0] cur, input int lat, input logic randRes);
    for (int k = 0; k < 40 && cur != ST_WAIT && cur != ST_GAME_OVER && cur != ST_FAULT; k++) begin
      logic vm, ht;
      vm = randRes ? ($urandom_range(0, 3) != 0) : 1'b1;
      ht = randRes ? ($urandom_range(0, 4) != 0) : 1'b1;
      checks++;
      if (state !== cur || obs !== expOut(cur)) begin
        errors++;
        $display("FAIL walk_stage: state=%0d outs=%b, want state=%0d outs=%b", state, obs, cur, expOut(cur));
      end
      serve(lat < 0 ? int'($urandom_range(0, 6)) : lat, vm, ht);
      cur = nextOf(cur, vm, ht);
    end
    checks++;
    if (state !== cur) begin
      errors++;
      $display("FAIL walk_end: state=%0d, want %0d", state, cur);
    end
  endtask

  task automatic pressEnterTo(input logic [4:0] tgt, input string name);
    setKeys(5'b10000); step(2); setKeys(5'b0);
    checks++;
    if (state !== tgt || obs !== expOut(tgt)) begin
      errors++;
      $display("FAIL %s: state=%0d outs=%b, want state=%0d outs=%b", name, state, obs, tgt, expOut(tgt));
    end
  endtask

  task automatic test_reset();
    resetn = 1; step(3);
    checks++;
    if (state !== ST_RESET || obs !== expOut(ST_RESET)) begin
      errors++;
      $display("FAIL reset_state: state=%0d outs=%b, want state=%0d outs=%b", state, obs, ST_RESET, expOut(ST_RESET));
    end
    resetn = 0;
  endtask

  task automatic test_startup();
    logic [4:0] cur;
    cur = ST_RESET;
    walk(cur, 3, 1'b0);
    checks++;
    if (obs !== 20'b0) begin
      errors++;
      $display("FAIL startup_wait_outs: outs=%b, want 0", obs);
    end
  endtask

  task automatic test_keys();
    int snap;
    snap = mrCnt;
    setKeys(5'b01010);
    step(1);
    checks++;
    if (state !== ST_WAIT) begin
      errors++;
      $display("FAIL key_latency: state=%0d one cycle after press, want %0d", state, ST_WAIT);
    end
    step(1);
    checks++;
    if (state !== ST_MOVE_R || obs !== expOut(ST_MOVE_R)) begin
      errors++;
      $display("FAIL key_priority: state=%0d outs=%b, want state=%0d", state, obs, ST_MOVE_R);
    end
    step(1);
    checks++;
    if (state !== ST_HIGHLIGHT || moveRightEn !== 1'b0) begin
      errors++;
      $display("FAIL move_one_cycle: state=%0d moveRightEn=%b, want state=%0d moveRightEn=0", state, moveRightEn, ST_HIGHLIGHT);
    end
    serve(3, 0, 0);
    step(50);
    checks++;
    if (mrCnt - snap != 1 || state !== ST_WAIT) begin
      errors++;
      $display("FAIL key_hold: pulses=%0d state=%0d, want pulses=1 state=%0d", mrCnt - snap, state, ST_WAIT);
    end
    setKeys(5'b0); step(2);
  endtask

  task automatic test_invalid_move();
    int snap;
    snap = plCnt;
    pressEnterTo(ST_CHECK, "enter_to_check");
    serve(2, 1'b0, 1'b1);
    checks++;
    if (state !== ST_WAIT || plCnt != snap) begin
      errors++;
      $display("FAIL invalid_move: state=%0d placePulses=%0d, want state=%0d placePulses=0", state, plCnt - snap, ST_WAIT);
    end
  endtask

  task automatic test_full_turn();
    logic [4:0] seq [6];
    seq = '{ST_PLACE, ST_FLIP, ST_SCORE, ST_OPP, ST_SWAP, ST_HIGHLIGHT};
    pressEnterTo(ST_CHECK, "turn_check");
    serve(1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (state !== seq[i] || obs !== expOut(seq[i])) begin
        errors++;
        $display("FAIL full_turn[%0d]: state=%0d outs=%b, want state=%0d outs=%b", i, state, obs, seq[i], expOut(seq[i]));
      end
      serve(3, 1'b1, 1'b1);
    end
    checks++;
    if (state !== ST_WAIT) begin
      errors++;
      $display("FAIL full_turn_end: state=%0d, want %0d", state, ST_WAIT);
    end
  endtask

  task automatic test_game_end();
    logic [4:0] cur;
    pressEnterTo(ST_CHECK, "end_check");
    serve(0, 1'b1, 1'b1); serve(0, 1'b1, 1'b1); serve(0, 1'b1, 1'b1); serve(0, 1'b1, 1'b1);
    checks++;
    if (state !== ST_OPP) begin
      errors++;
      $display("FAIL end_opp: state=%0d, want %0d", state, ST_OPP);
    end
    serve(2, 1'b0, 1'b0);
`ifdef PASS_TURN_EN
    checks++;
    if (state !== ST_CUR || determineCurrent !== 1'b1) begin
      errors++;
      $display("FAIL end_cur: state=%0d determineCurrent=%b, want state=%0d 1", state, determineCurrent, ST_CUR);
    end
    serve(2, 1'b0, 1'b0);
`endif
    checks++;
    if (state !== ST_END || obs !== expOut(ST_END)) begin
      errors++;
      $display("FAIL end_state: state=%0d outs=%b, want state=%0d outs=%b", state, obs, ST_END, expOut(ST_END));
    end
    serve(1, 1'b0, 1'b0);
    checks++;
    if (state !== ST_GAME_OVER || game_over !== 1'b1) begin
      errors++;
      $display("FAIL game_over: state=%0d game_over=%b, want state=%0d 1", state, game_over, ST_GAME_OVER);
    end
    setKeys(5'b01111); step(3); setKeys(5'b0); step(1);
    checks++;
    if (state !== ST_GAME_OVER) begin
      errors++;
      $display("FAIL game_over_keys: state=%0d, want %0d", state, ST_GAME_OVER);
    end
    pressEnterTo(ST_RESET, "game_over_enter");
    cur = ST_RESET;
    walk(cur, 2, 1'b0);
`ifndef PASS_TURN_EN
    checks++;
    if (dcurCnt != 0) begin
      errors++;
      $display("FAIL determine_current_tied: cycles high=%0d, want 0", dcurCnt);
    end
`endif
  endtask

  task automatic test_watchdog();
    logic [4:0] cur;
    pressEnterTo(ST_CHECK, "wd_check");
    serve(0, 1'b1, 1'b1); serve(0, 1'b1, 1'b1);
    step(10);
    checks++;
    if (state !== ST_FLIP || fault !== 1'b0) begin
      errors++;
      $display("FAIL wd_early: state=%0d fault=%b, want state=%0d fault=0", state, fault, ST_FLIP);
    end
    step(7);
    checks++;
    if (state !== ST_FAULT || obs !== expOut(ST_FAULT)) begin
      errors++;
      $display("FAIL wd_fault: state=%0d outs=%b, want state=%0d outs=%b", state, obs, ST_FAULT, expOut(ST_FAULT));
    end
    go = 1; setKeys(5'b10000); step(2); go = 0; setKeys(5'b0); step(10);
    checks++;
    if (state !== ST_FAULT || fault !== 1'b1) begin
      errors++;
      $display("FAIL wd_sticky: state=%0d fault=%b, want state=%0d fault=1", state, fault, ST_FAULT);
    end
    resetn = 1; step(1); resetn = 0;
    cur = ST_RESET;
    walk(cur, 1, 1'b0);
  endtask

  task automatic test_mid_reset();
    logic [4:0] cur;
    pressEnterTo(ST_CHECK, "mr_check");
    serve(0, 1'b1, 1'b1); serve(0, 1'b1, 1'b1);
    step(1);
    #2 resetn = 1;
    #1;
    checks++;
    if (flipEn !== 1'b0 || state !== ST_RESET || dp_reset !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: flipEn=%b state=%0d dp_reset=%b, want 0 %0d 1", flipEn, state, dp_reset, ST_RESET);
    end
    @(negedge clk) resetn = 0;
    cur = ST_RESET;
    walk(cur, 3, 1'b0);
  endtask

  task automatic test_random_play();
    logic [4:0] cur, m, tgt;
    for (int t = 0; t < 40; t++) begin
      m = 5'($urandom_range(1, 31));
      tgt = m[4] ? ST_CHECK : m[3] ? ST_MOVE_R : m[2] ? ST_MOVE_L : m[1] ? ST_MOVE_U : ST_MOVE_D;
      setKeys(m); step(2); setKeys(5'b0);
      checks++;
      if (state !== tgt || obs !== expOut(tgt)) begin
        errors++;
        $display("FAIL rand_key mask=%b: state=%0d outs=%b, want state=%0d", m, state, obs, tgt);
      end
      if (tgt == ST_CHECK) cur = ST_CHECK;
      else begin step(1); cur = ST_HIGHLIGHT; end
      walk(cur, -1, 1'b1);
      if (cur == ST_GAME_OVER) begin
        pressEnterTo(ST_RESET, "rand_restart");
        cur = ST_RESET;
        walk(cur, -1, 1'b1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_keys();
    test_invalid_move();
    test_full_turn();
    test_game_end();
    test_watchdog();
    test_mid_reset();
    test_random_play();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
